// File: rtl/regfile_mp_if.sv
// Register file access bundle: one write port, NUM_RD read ports,
// plus the clear-sequencer busy flag.
interface regfile_mp_if #(
    parameter int XLEN   = 32,
    parameter int ADDR_W = 5,
    parameter int NUM_RD = 2
);
    logic                     init_busy;
    logic                     wr_en;
    logic [ADDR_W-1:0]        wr_addr;
    logic [XLEN-1:0]          wr_data;
    logic                     rd_en;
    logic [NUM_RD*ADDR_W-1:0] rd_addr;
    logic [NUM_RD*XLEN-1:0]   rd_data;

    modport master (
        input  init_busy,
        input  rd_data,
        output wr_en,
        output wr_addr,
        output wr_data,
        output rd_en,
        output rd_addr
    );

    modport slave (
        output init_busy,
        output rd_data,
        input  wr_en,
        input  wr_addr,
        input  wr_data,
        input  rd_en,
        input  rd_addr
    );
endinterface

// File: rtl/regfile_mp.sv
// Parametrised multi-read-port register file with registered reads,
// optional write-to-read bypass and a post-reset clear sequencer.
module regfile_mp #(
    parameter int XLEN   = 32,
    parameter int ADDR_W = 5,
    parameter int NUM_RD = 2,
    parameter int BYPASS = 1
) (
    input  logic         clk,
    input  logic         rst,
    regfile_mp_if.slave  bus
);
    localparam int DEPTH = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] LAST = '1;

    typedef enum logic {INIT, RUN} state_t;

    state_t                 state_q, state_d;
    logic [ADDR_W-1:0]      clr_q, clr_d;
    logic                   busy_q;
    logic [XLEN-1:0]        mem [DEPTH];
    logic [ADDR_W-1:0]      ra [NUM_RD];
    logic [XLEN-1:0]        rd_d [NUM_RD];
    logic [NUM_RD*XLEN-1:0] rd_flat;
    logic [NUM_RD*XLEN-1:0] rd_q;
    logic                   wr_ok;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= INIT;
            clr_q   <= ADDR_W'(1);
            busy_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            clr_q   <= clr_d;
            busy_q  <= (state_d == INIT);
        end
    end

    always_comb begin
        state_d = state_q;
        clr_d   = clr_q;
        unique case (state_q)
            INIT: begin
                if (clr_q == LAST) state_d = RUN;
                else clr_d = clr_q + ADDR_W'(1);
            end
            RUN: state_d = RUN;
            default: state_d = INIT;
        endcase
    end

    assign wr_ok = (state_q == RUN) && bus.wr_en
                   && (bus.wr_addr != '0);

    // Entry 0 is never written; reads of address 0 are forced to zero.
    always_ff @(posedge clk) begin
        if (state_q == INIT) mem[clr_q] <= '0;
        else if (wr_ok) mem[bus.wr_addr] <= bus.wr_data;
    end

    for (genvar p = 0; p < NUM_RD; p++) begin : g_port
        assign ra[p] = bus.rd_addr[p*ADDR_W +: ADDR_W];

        always_comb begin
            rd_d[p] = mem[ra[p]];
            if (state_q != RUN || ra[p] == '0)
                rd_d[p] = '0;
            else if (BYPASS != 0 && bus.wr_en
                     && bus.wr_addr == ra[p])
                rd_d[p] = bus.wr_data;
        end

        assign rd_flat[p*XLEN +: XLEN] = rd_d[p];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) rd_q <= '0;
        else if (bus.rd_en) rd_q <= rd_flat;
    end

    assign bus.rd_data   = rd_q;
    assign bus.init_busy = busy_q;
endmodule
